// File: rtl/complete_queue.sv
// -----------------------------------------------------------------------------
// complete_queue
//
// Producer end of the `complete` broadcast. Finished results from NUM_FU
// functional units are accepted through a valid/ready handshake, buffered in
// an in-order circular FIFO and broadcast up to WIDTH per cycle from
// registered outputs to the reservation stations, ROB and map table.
// A flush squashes every buffered and in-flight completion.
//
// Handshake: an FU transfers a result in a cycle where fu_valid[i] and
// fu_ready[i] are both high. fu_ready[i] depends only on queue state, flush,
// reset and the valid bits of lower-index FUs, never on fu_valid[i] itself.
// The cdb side has no backpressure: each lane is valid for exactly one cycle
// per completion.
//
// Optional feature macro: COMPLETE_QUEUE_BYPASS_EN
//   defined   -> when the queue is empty and not flushing, up to WIDTH accepted
//                results load the cdb registers directly (1-cycle latency).
//   undefined -> every result goes through the FIFO (2-cycle latency).
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   flush         squash all buffered / in-flight completions
//   fu_valid      [NUM_FU]  FU presents a result
//   fu_ready      [NUM_FU]  queue accepts that FU's result this cycle
//   fu_dst        [NUM_FU]  destination physical register
//   fu_rob_idx    [NUM_FU]  ROB index
//   fu_exc_valid  [NUM_FU]  result raised an exception
//   fu_exc        [NUM_FU]  exception cause
//   cdb           complete.cq modport: valid, dst, rob_idx, exc_valid, exc
// -----------------------------------------------------------------------------

package complete_pkg;
    typedef logic [5:0] phy_reg_t;
    typedef logic [4:0] rob_idx_t;
    typedef logic [3:0] exc_t;
endpackage

// Completion broadcast bundle, WIDTH lanes.
interface complete
    import complete_pkg::*;
#(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] valid;
    phy_reg_t         dst       [WIDTH];
    rob_idx_t         rob_idx   [WIDTH];
    logic [WIDTH-1:0] exc_valid;
    exc_t             exc       [WIDTH];

    modport cq (output valid, dst, rob_idx, exc_valid, exc);
    modport rs (input  valid, dst, rob_idx, exc_valid, exc);
endinterface

module complete_queue
    import complete_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [NUM_FU-1:0] fu_valid,
    output logic [NUM_FU-1:0] fu_ready,
    input  phy_reg_t          fu_dst       [NUM_FU],
    input  rob_idx_t          fu_rob_idx   [NUM_FU],
    input  logic [NUM_FU-1:0] fu_exc_valid,
    input  exc_t              fu_exc       [NUM_FU],
    complete.cq               cdb
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // FIFO storage (no reset needed: only entries between head and tail are read)
    phy_reg_t ent_dst  [DEPTH];
    rob_idx_t ent_rob  [DEPTH];
    logic     ent_excv [DEPTH];
    exc_t     ent_exc  [DEPTH];

    ptr_t head;
    ptr_t tail;
    cnt_t count;

    // Registered broadcast outputs
    logic [WIDTH-1:0] valid_r;
    phy_reg_t         dst_r  [WIDTH];
    rob_idx_t         rob_r  [WIDTH];
    logic [WIDTH-1:0] excv_r;
    exc_t             exc_r  [WIDTH];

    // Per-cycle control
    cnt_t              free;
    cnt_t              rank   [NUM_FU];
    logic [NUM_FU-1:0] accept;
    cnt_t              acc_n;
    cnt_t              pop_n;
    cnt_t              byp_n;
    cnt_t              push_n;

    // Next-lane values
    logic [WIDTH-1:0] lane_ld;
    phy_reg_t         lane_dst  [WIDTH];
    rob_idx_t         lane_rob  [WIDTH];
    logic [WIDTH-1:0] lane_excv;
    exc_t             lane_exc  [WIDTH];

    assign free = cnt_t'(DEPTH) - count;

    // rank[i] = number of lower-index FUs presenting a result. Because ready is
    // "free > rank", the accepted FUs always form a prefix of the valid ones, so
    // rank[i] is also the accepted FU's slot offset from tail.
    always_comb begin
        cnt_t seen;
        seen  = '0;
        acc_n = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            rank[i]     = seen;
            fu_ready[i] = !reset && !flush && (free > seen);
            accept[i]   = fu_valid[i] && fu_ready[i];
            if (fu_valid[i]) seen = seen + cnt_t'(1);
            if (accept[i]) acc_n = acc_n + cnt_t'(1);
        end
    end

    assign pop_n = (count > cnt_t'(WIDTH)) ? cnt_t'(WIDTH) : count;

`ifdef COMPLETE_QUEUE_BYPASS_EN
    // Bypass only when the FIFO is empty, so pop_n is zero and lanes are free.
    assign byp_n = (count == '0 && !flush)
                   ? ((acc_n > cnt_t'(WIDTH)) ? cnt_t'(WIDTH) : acc_n)
                   : '0;
`else
    assign byp_n = '0;
`endif

    assign push_n = acc_n - byp_n;

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            lane_ld[k]   = 1'b0;
            lane_dst[k]  = dst_r[k];
            lane_rob[k]  = rob_r[k];
            lane_excv[k] = excv_r[k];
            lane_exc[k]  = exc_r[k];
            if (cnt_t'(k) < pop_n) begin
                lane_ld[k]   = 1'b1;
                lane_dst[k]  = ent_dst[head + ptr_t'(k)];
                lane_rob[k]  = ent_rob[head + ptr_t'(k)];
                lane_excv[k] = ent_excv[head + ptr_t'(k)];
                lane_exc[k]  = ent_exc[head + ptr_t'(k)];
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i] && rank[i] == cnt_t'(k) && rank[i] < byp_n) begin
                    lane_ld[k]   = 1'b1;
                    lane_dst[k]  = fu_dst[i];
                    lane_rob[k]  = fu_rob_idx[i];
                    lane_excv[k] = fu_exc_valid[i];
                    lane_exc[k]  = fu_exc[i];
                end
            end
        end
    end

    // Pointers, occupancy and broadcast registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_r <= '0;
            excv_r  <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                dst_r[k] <= '0;
                rob_r[k] <= '0;
                exc_r[k] <= '0;
            end
        end else if (flush) begin
            // Squash: whatever was popped this cycle is dropped; payload fields hold.
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_r <= '0;
        end else begin
            head    <= head + ptr_t'(pop_n);
            tail    <= tail + ptr_t'(push_n);
            count   <= count + push_n - pop_n;
            valid_r <= lane_ld;
            for (int k = 0; k < WIDTH; k++) begin
                if (lane_ld[k]) begin
                    dst_r[k]  <= lane_dst[k];
                    rob_r[k]  <= lane_rob[k];
                    excv_r[k] <= lane_excv[k];
                    exc_r[k]  <= lane_exc[k];
                end
            end
        end
    end

    // FIFO writes; accept is already low under reset and flush.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i] && rank[i] >= byp_n) begin
                ent_dst[tail + ptr_t'(rank[i] - byp_n)]  <= fu_dst[i];
                ent_rob[tail + ptr_t'(rank[i] - byp_n)]  <= fu_rob_idx[i];
                ent_excv[tail + ptr_t'(rank[i] - byp_n)] <= fu_exc_valid[i];
                ent_exc[tail + ptr_t'(rank[i] - byp_n)]  <= fu_exc[i];
            end
        end
    end

    assign cdb.valid     = valid_r;
    assign cdb.dst       = dst_r;
    assign cdb.rob_idx   = rob_r;
    assign cdb.exc_valid = excv_r;
    assign cdb.exc       = exc_r;

endmodule

// File: tb/tb_complete_queue.sv
// -----------------------------------------------------------------------------
// tb_complete_queue
//
// Directed bench for complete_queue (default build, FIFO latency of 2 cycles).
// Covers reset state, single result, same-cycle burst ordering, sustained
// backpressure with pointer wrap, flush, exception pass-through and reset
// in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_complete_queue;
    import complete_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic [3:0] fu_valid;
    logic [3:0] fu_ready;
    phy_reg_t   fu_dst       [4];
    rob_idx_t   fu_rob_idx   [4];
    logic [3:0] fu_exc_valid;
    exc_t       fu_exc       [4];

    complete #(.WIDTH(3)) cdb_if ();

    complete_queue #(.WIDTH(3), .NUM_FU(4), .DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_dst       (fu_dst),
        .fu_rob_idx   (fu_rob_idx),
        .fu_exc_valid (fu_exc_valid),
        .fu_exc       (fu_exc),
        .cdb          (cdb_if)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];
    int n_pushed = 0;
    int n_popped = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_fu();
        fu_valid     = '0;
        fu_exc_valid = '0;
        for (int i = 0; i < 4; i++) begin
            fu_dst[i]     = '0;
            fu_rob_idx[i] = '0;
            fu_exc[i]     = '0;
        end
    endtask

    task automatic drive_fu(input int i, input int dst, input int rob, input logic excv, input int exc);
        fu_valid[i]     = 1'b1;
        fu_dst[i]       = phy_reg_t'(dst);
        fu_rob_idx[i]   = rob_idx_t'(rob);
        fu_exc_valid[i] = excv;
        fu_exc[i]       = exc_t'(exc);
    endtask

    // Compare every valid cdb lane, in lane order, against the expected queue.
    task automatic sb_collect();
        for (int k = 0; k < 3; k++) begin
            if (cdb_if.valid[k]) begin
                n_popped++;
                if (exp_q.size() == 0) begin
                    check("sb_extra_lane", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    check("sb_rob_order", 32'(cdb_if.rob_idx[k]), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int next_rob;
        logic [3:0] exp_ready;

        // ---------------- reset state ----------------
        reset = 1'b1;
        flush = 1'b0;
        clear_fu();
        fu_valid = 4'hF;
        #2;
        check("rst_ready", 32'(fu_ready), 32'h0);
        check("rst_valid", 32'(cdb_if.valid), 32'h0);
        check("rst_dst0", 32'(cdb_if.dst[0]), 32'h0);
        check("rst_rob2", 32'(cdb_if.rob_idx[2]), 32'h0);
        check("rst_excv", 32'(cdb_if.exc_valid), 32'h0);
        clear_fu();
        step();
        step();
        reset = 1'b0;

        // ---------------- single result ----------------
        drive_fu(0, 5, 2, 1'b0, 0);
        #1;
        check("single_ready", 32'(fu_ready), 32'hF);
        step();
        clear_fu();
        check("single_n1_valid", 32'(cdb_if.valid), 32'h0);
        step();
        check("single_n2_valid", 32'(cdb_if.valid), 32'h1);
        check("single_n2_dst0", 32'(cdb_if.dst[0]), 32'd5);
        check("single_n2_rob0", 32'(cdb_if.rob_idx[0]), 32'd2);
        step();
        check("single_n3_valid", 32'(cdb_if.valid), 32'h0);

        // ---------------- burst ordering ----------------
        for (int i = 0; i < 4; i++) drive_fu(i, 20 + i, 10 + i, 1'b0, 0);
        #1;
        check("burst_ready", 32'(fu_ready), 32'hF);
        step();
        clear_fu();
        check("burst_n1_valid", 32'(cdb_if.valid), 32'h0);
        step();
        check("burst_n2_valid", 32'(cdb_if.valid), 32'h7);
        check("burst_n2_rob0", 32'(cdb_if.rob_idx[0]), 32'd10);
        check("burst_n2_rob1", 32'(cdb_if.rob_idx[1]), 32'd11);
        check("burst_n2_rob2", 32'(cdb_if.rob_idx[2]), 32'd12);
        check("burst_n2_dst0", 32'(cdb_if.dst[0]), 32'd20);
        step();
        check("burst_n3_valid", 32'(cdb_if.valid), 32'h1);
        check("burst_n3_rob0", 32'(cdb_if.rob_idx[0]), 32'd13);
        check("burst_n3_rob1_hold", 32'(cdb_if.rob_idx[1]), 32'd11);
        step();
        check("burst_n4_valid", 32'(cdb_if.valid), 32'h0);

        // ---------------- sustained traffic, backpressure, wrap ----------------
        // All four FUs held valid from empty: occupancy goes 0 -> 4 -> 5 and then
        // stays at 5 (3 free), so ready is 1111, 1111, then 0111 thereafter.
        next_rob = 0;
        for (int t = 0; t < 20; t++) begin
            sb_collect();
            for (int i = 0; i < 4; i++) drive_fu(i, i, (next_rob + i) % 32, 1'b0, 0);
            #1;
            exp_ready = (t < 2) ? 4'hF : 4'h7;
            check("wrap_ready", 32'(fu_ready), 32'(exp_ready));
            for (int i = 0; i < 4; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    exp_q.push_back(5'((next_rob + i) % 32));
                    n_pushed++;
                end
            end
            next_rob = next_rob + ((t < 2) ? 4 : 3);
            step();
        end
        clear_fu();
        sb_collect();
        for (int t = 0; t < 6; t++) begin
            step();
            sb_collect();
        end
        check("wrap_left", 32'(exp_q.size()), 32'd0);
        check("wrap_pushed", 32'(n_pushed), 32'd62);
        check("wrap_popped", 32'(n_popped), 32'd62);
        check("wrap_idle_valid", 32'(cdb_if.valid), 32'h0);

        // ---------------- flush ----------------
        for (int i = 0; i < 4; i++) drive_fu(i, 0, i, 1'b0, 0);
        step();
        for (int i = 0; i < 4; i++) drive_fu(i, 0, 4 + i, 1'b0, 0);
        #1;
        check("flush_pre_ready", 32'(fu_ready), 32'hF);
        step();
        // five entries buffered, lanes showing 0,1,2
        clear_fu();
        check("flush_pre_valid", 32'(cdb_if.valid), 32'h7);
        flush = 1'b1;
        drive_fu(1, 7, 30, 1'b0, 0);
        #1;
        check("flush_ready", 32'(fu_ready), 32'h0);
        step();
        flush = 1'b0;
        clear_fu();
        check("flush_n1_valid", 32'(cdb_if.valid), 32'h0);
        check("flush_n1_rob2_hold", 32'(cdb_if.rob_idx[2]), 32'd2);
        step();
        check("flush_n2_valid", 32'(cdb_if.valid), 32'h0);
        step();
        check("flush_n3_valid", 32'(cdb_if.valid), 32'h0);
        drive_fu(3, 1, 9, 1'b0, 0);
        #1;
        check("flush_after_ready", 32'(fu_ready), 32'hF);
        step();
        clear_fu();
        check("flush_after_n1_valid", 32'(cdb_if.valid), 32'h0);
        step();
        check("flush_after_n2_valid", 32'(cdb_if.valid), 32'h1);
        check("flush_after_n2_rob0", 32'(cdb_if.rob_idx[0]), 32'd9);
        step();
        check("flush_after_n3_valid", 32'(cdb_if.valid), 32'h0);

        // ---------------- exception pass-through ----------------
        drive_fu(2, 9, 17, 1'b1, 3);
        step();
        clear_fu();
        step();
        check("exc_valid", 32'(cdb_if.valid), 32'h1);
        check("exc_rob0", 32'(cdb_if.rob_idx[0]), 32'd17);
        check("exc_dst0", 32'(cdb_if.dst[0]), 32'd9);
        check("exc_excv", 32'(cdb_if.exc_valid), 32'h1);
        check("exc_code0", 32'(cdb_if.exc[0]), 32'd3);
        step();
        check("exc_after_valid", 32'(cdb_if.valid), 32'h0);

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 4; i++) drive_fu(i, 30 + i, 20 + i, 1'b0, 0);
        step();
        clear_fu();
        step();
        check("midrst_pre_valid", 32'(cdb_if.valid), 32'h7);
        check("midrst_pre_rob0", 32'(cdb_if.rob_idx[0]), 32'd20);
        reset = 1'b1;
        fu_valid = 4'hF;
        #1;
        check("midrst_valid", 32'(cdb_if.valid), 32'h0);
        check("midrst_rob0", 32'(cdb_if.rob_idx[0]), 32'h0);
        check("midrst_dst1", 32'(cdb_if.dst[1]), 32'h0);
        check("midrst_ready", 32'(fu_ready), 32'h0);
        step();
        clear_fu();
        reset = 1'b0;
        step();
        check("midrst_n1_valid", 32'(cdb_if.valid), 32'h0);
        step();
        check("midrst_n2_valid", 32'(cdb_if.valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
